// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the CPU request/response, external load/debug port
//               and single-port data SRAM signals served by dmem_arbiter.
//               modport slave  : the arbiter (takes requests, drives SRAM)
//               modport master : the environment (CPU, EXT port, SRAM model)
// Ports       : cpu_req/cpu_wen/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ack/cpu_stall
//               ext_req/ext_wen/ext_addr/ext_wdata -> ext_rdata/ext_ack
//               err, owner, mem_en/mem_wen/mem_addr/mem_wdata <- mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              cpu_req;
    logic              cpu_wen;
    logic [63:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_wen;
    logic [63:0]       ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_ack;

    logic              err;
    logic              owner;

    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  ext_req, ext_wen, ext_addr, ext_wdata,
        output ext_rdata, ext_ack,
        output err, owner,
        output mem_en, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output ext_req, ext_wen, ext_addr, ext_wdata,
        input  ext_rdata, ext_ack,
        input  err, owner,
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates the CPU MEM-stage port and an external load/debug
//               port onto one single-port data SRAM. Three-state FSM
//               (IDLE -> ISSUE -> RESP), one access per three cycles. CPU has
//               priority, but after STARVE_MAX consecutive contested CPU wins
//               the external port is granted. Misaligned or out-of-range
//               accesses are not issued to the SRAM and complete with err.
// Ports       : clk, rst (sync, active-high)
//               bus : dmem_arbiter_if.slave (CPU, EXT, SRAM and status signals)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    state_t            r_state;
    logic [3:0]        r_starve_cnt;
    logic              r_owner;
    logic              r_wen;
    logic              r_bad;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_en;
    logic              r_mem_wen;
    logic              r_cpu_ack;
    logic              r_ext_ack;
    logic              r_err;
    logic              r_rd_ok;

    logic              w_any;
    logic              w_both;
    logic              w_pick_ext;
    logic              w_sel_wen;
    logic [63:0]       w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_bad;

    assign w_any  = bus.cpu_req | bus.ext_req;
    assign w_both = bus.cpu_req & bus.ext_req;

    // EXT wins when it is alone, or when the CPU has used up its allowance of
    // consecutive contested wins.
    assign w_pick_ext = bus.ext_req & (~bus.cpu_req | (r_starve_cnt == c_starve_max));

    assign w_sel_wen   = w_pick_ext ? bus.ext_wen   : bus.cpu_wen;
    assign w_sel_addr  = w_pick_ext ? bus.ext_addr  : bus.cpu_addr;
    assign w_sel_wdata = w_pick_ext ? bus.ext_wdata : bus.cpu_wdata;

    // Byte address must be word-aligned and fit within the SRAM word range.
    assign w_sel_bad = (w_sel_addr[2:0] != 3'b000) | (|w_sel_addr[63:ADDR_W+3]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            r_owner      <= 1'b0;
            r_wen        <= 1'b0;
            r_bad        <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_mem_en     <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_ext_ack    <= 1'b0;
            r_err        <= 1'b0;
            r_rd_ok      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cpu_ack <= 1'b0;
                    r_ext_ack <= 1'b0;
                    r_err     <= 1'b0;
                    r_rd_ok   <= 1'b0;
                    if (w_any) begin
                        r_state   <= S_ISSUE;
                        r_owner   <= w_pick_ext;
                        r_wen     <= w_sel_wen;
                        r_bad     <= w_sel_bad;
                        r_waddr   <= w_sel_addr[ADDR_W+2:3];
                        r_wdata   <= w_sel_wdata;
                        // SRAM strobes are registered here so they are valid
                        // for the whole ISSUE cycle.
                        r_mem_en  <= ~w_sel_bad;
                        r_mem_wen <= w_sel_wen & ~w_sel_bad;
                        if (w_pick_ext) begin
                            r_starve_cnt <= 4'd0;
                        end else if (w_both && (r_starve_cnt < c_starve_max)) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state   <= S_RESP;
                    r_mem_en  <= 1'b0;
                    r_mem_wen <= 1'b0;
                    r_cpu_ack <= ~r_owner;
                    r_ext_ack <= r_owner;
                    r_err     <= r_bad;
                    r_rd_ok   <= ~r_wen & ~r_bad;
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_cpu_ack <= 1'b0;
                    r_ext_ack <= 1'b0;
                    r_err     <= 1'b0;
                    r_rd_ok   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_wen   = r_mem_wen;
    assign bus.mem_addr  = r_waddr;
    assign bus.mem_wdata = r_wdata;

    // SRAM read data arrives during RESP, so it is steered straight to the
    // owner; all other cycles and the non-owner see zero.
    assign bus.cpu_rdata = (r_cpu_ack & r_rd_ok) ? bus.mem_rdata : '0;
    assign bus.ext_rdata = (r_ext_ack & r_rd_ok) ? bus.mem_rdata : '0;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.ext_ack   = r_ext_ack;
    assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack;
    assign bus.err       = r_err;
    assign bus.owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. Directed accesses with a
//               scoreboard of expected responses; a behavioural SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 64;
    localparam int STARVE_MAX = 4;

    typedef struct {
        bit          port;
        logic [63:0] data;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_acks = 0;
    exp_t exp_q[$];
    exp_t e_mon;

    // Single-port SRAM model: registered read, data valid the cycle after mem_en.
    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (rst) begin
            sram[0] <= 64'h1234;
            sram[2] <= 64'hDEAD;
        end else if (bus.mem_en) begin
            if (bus.mem_wen) sram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= sram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every ack.
    always @(negedge clk) begin
        if (bus.cpu_ack || bus.ext_ack) begin
            n_acks++;
            check("ack_onehot", 64'(bus.cpu_ack & bus.ext_ack), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack_q", 64'(exp_q.size()), 64'd1);
            end else begin
                e_mon = exp_q.pop_front();
                check("ack_port", 64'(bus.ext_ack), 64'(e_mon.port));
                check("owner", 64'(bus.owner), 64'(e_mon.port));
                check("err", 64'(bus.err), 64'(e_mon.err));
                if (e_mon.port) begin
                    check("ext_rdata", 64'(bus.ext_rdata), e_mon.data);
                    check("cpu_rdata_nonowner", 64'(bus.cpu_rdata), 64'd0);
                end else begin
                    check("cpu_rdata", 64'(bus.cpu_rdata), e_mon.data);
                    check("ext_rdata_nonowner", 64'(bus.ext_rdata), 64'd0);
                end
            end
        end
    end

    // Called at edge+#1 of an IDLE cycle; returns at edge+#1 of the next IDLE.
    task automatic access(input bit port, input bit wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_data,
                          input bit exp_err, input string tag);
        logic [63:0] waddr;
        waddr = 64'(addr[ADDR_W+2:3]);
        if (port) begin
            bus.ext_req = 1'b1; bus.ext_wen = wen; bus.ext_addr = addr; bus.ext_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_wen = wen; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
        exp_q.push_back('{port: port, data: exp_data, err: exp_err});
        #1;
        check({tag, "_idle_mem_en"}, 64'(bus.mem_en), 64'd0);
        if (!port) check({tag, "_stall_c0"}, 64'(bus.cpu_stall), 64'd1);
        @(posedge clk); #1;
        check({tag, "_issue_mem_en"}, 64'(bus.mem_en), 64'(!exp_err));
        check({tag, "_issue_mem_wen"}, 64'(bus.mem_wen), 64'(wen && !exp_err));
        if (!exp_err) check({tag, "_issue_addr"}, 64'(bus.mem_addr), waddr);
        if (wen && !exp_err) check({tag, "_issue_wdata"}, 64'(bus.mem_wdata), wdata);
        if (!port) check({tag, "_stall_c1"}, 64'(bus.cpu_stall), 64'd1);
        @(posedge clk); #1;
        check({tag, "_resp_ack"}, 64'(port ? bus.ext_ack : bus.cpu_ack), 64'd1);
        if (!port) check({tag, "_stall_c2"}, 64'(bus.cpu_stall), 64'd0);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        bus.ext_req = 1'b0;
        check({tag, "_ack_one_cycle"}, 64'(bus.cpu_ack | bus.ext_ack), 64'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_wen = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_req = 1'b0; bus.ext_wen = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_mem_en", 64'(bus.mem_en), 64'd0);
        check("rst_mem_wen", 64'(bus.mem_wen), 64'd0);
        check("rst_cpu_ack", 64'(bus.cpu_ack), 64'd0);
        check("rst_ext_ack", 64'(bus.ext_ack), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
        check("rst_ext_rdata", 64'(bus.ext_rdata), 64'd0);
        check("rst_owner", 64'(bus.owner), 64'd0);
        check("rst_cpu_stall", 64'(bus.cpu_stall), 64'd0);

        // CPU read of word 2
        access(1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD, 1'b0, "cpu_rd");
        // EXT write then read back
        access(1'b1, 1'b1, 64'h18, 64'h55, 64'h0, 1'b0, "ext_wr");
        access(1'b1, 1'b0, 64'h18, 64'h0, 64'h55, 1'b0, "ext_rd");
        // Rejected accesses: misaligned and out of range
        access(1'b0, 1'b0, 64'h13, 64'h0, 64'h0, 1'b1, "cpu_misalign");
        access(1'b0, 1'b0, 64'h1 << (ADDR_W + 3), 64'h0, 64'h0, 1'b1, "cpu_range");
        access(1'b0, 1'b1, 64'h14, 64'h77, 64'h0, 1'b1, "cpu_wr_misalign");
        access(1'b1, 1'b0, 64'h18, 64'h0, 64'h55, 1'b0, "ext_rd_after_rej");

        // Starvation: both requesters held high
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("starve_rst_cnt", 64'(dut.r_starve_cnt), 64'd0);
        base = n_acks;
        bus.cpu_req = 1'b1; bus.cpu_wen = 1'b0; bus.cpu_addr = 64'h10;
        bus.ext_req = 1'b1; bus.ext_wen = 1'b0; bus.ext_addr = 64'h18;
        repeat (STARVE_MAX) exp_q.push_back('{port: 1'b0, data: 64'hDEAD, err: 1'b0});
        exp_q.push_back('{port: 1'b1, data: 64'h55, err: 1'b0});
        exp_q.push_back('{port: 1'b0, data: 64'hDEAD, err: 1'b0});
        for (int i = 0; i < 40 && n_acks < base + STARVE_MAX + 2; i++) begin
            @(posedge clk); #1;
            if (bus.mem_en && bus.owner) check("starve_cnt_after_ext", 64'(dut.r_starve_cnt), 64'd0);
        end
        check("starve_grant_count", 64'(n_acks - base), 64'(STARVE_MAX + 2));
        bus.cpu_req = 1'b0;
        bus.ext_req = 1'b0;
        @(posedge clk); #1;

        // Reset during ISSUE of an EXT read, req held
        bus.ext_req = 1'b1; bus.ext_wen = 1'b0; bus.ext_addr = 64'h18;
        exp_q.push_back('{port: 1'b1, data: 64'h55, err: 1'b0});
        @(posedge clk); #1;
        check("rstabort_issue_mem_en", 64'(bus.mem_en), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstabort_no_ack", 64'(bus.ext_ack), 64'd0);
        check("rstabort_idle_mem_en", 64'(bus.mem_en), 64'd0);
        @(posedge clk); #1;
        check("rstabort_reissue_mem_en", 64'(bus.mem_en), 64'd1);
        check("rstabort_reissue_addr", 64'(bus.mem_addr), 64'd3);
        @(posedge clk); #1;
        check("rstabort_ack", 64'(bus.ext_ack), 64'd1);
        @(posedge clk); #1;
        bus.ext_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
